// File: rtl/mem_stream_pkg.sv
// Shared constants and FSM state type for the memory stream echo block.
package mem_stream_pkg;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 4096;
  localparam int ADDR_W = 12;

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DUMP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_sp_ram.sv
// Single-port synchronous RAM with one-cycle registered read; stands in for a foundry macro.
import mem_stream_pkg::*;

module mem_sp_ram #(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] q
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    q <= mem[addr];
  end

endmodule

// File: rtl/mem_stream_echo.sv
// Captures one burst of words into RAM and replays it in arrival order.
// Optional trailing checksum word enabled by defining MEM_CHECKSUM_EN.
import mem_stream_pkg::*;

module mem_stream_echo (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              overflow
);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
  logic [ADDR_W:0]     count;
  logic                rd_done;
  logic                rd_vld, rd_last;
  logic                ram_we, rd_issue;
  logic [ADDR_W-1:0]   ram_addr;
  logic [DATA_W-1:0]   ram_q;
  logic                full, rd_is_last;

  assign full       = (count == DEPTH_CNT);
  assign rd_is_last = ({1'b0, rd_ptr} == (count - CNT_ONE));

  mem_sp_ram #(.DW(DATA_W), .AW(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (in_data),
    .q     (ram_q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // DUMP is held until the last data word reaches the output register,
  // so in_valid is ignored for the whole replay window.
  always_comb begin
    state_nxt = state;
    ram_we    = 1'b0;
    ram_addr  = wr_ptr;
    rd_issue  = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_nxt = LOAD;
          ram_we    = 1'b1;
        end
      end
      LOAD: begin
        if (in_valid) ram_we = !full;
        else          state_nxt = DUMP;
      end
      DUMP: begin
        ram_addr = rd_ptr;
        rd_issue = !rd_done;
        if (rd_vld && rd_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_done  <= 1'b0;
      rd_vld   <= 1'b0;
      rd_last  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      rd_vld  <= rd_issue;
      rd_last <= rd_issue && rd_is_last;
      case (state)
        IDLE: begin
          if (in_valid) begin
            wr_ptr <= ADDR_W'(1);
            count  <= CNT_ONE;
          end
        end
        LOAD: begin
          if (in_valid) begin
            if (full) begin
              overflow <= 1'b1;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
              count  <= count + CNT_ONE;
            end
          end
        end
        DUMP: begin
          if (rd_vld && rd_last) begin
            rd_ptr  <= '0;
            rd_done <= 1'b0;
            wr_ptr  <= '0;
            count   <= '0;
          end else if (rd_issue) begin
            if (rd_is_last) rd_done <= 1'b1;
            else            rd_ptr  <= rd_ptr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_CHECKSUM_EN
  logic [DATA_W-1:0] sum;
  logic              sum_pend;

  // The sum is only rewritten by a new burst, which cannot be sampled
  // before the edge that emits the checksum, so no snapshot is needed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum      <= '0;
      sum_pend <= 1'b0;
    end else begin
      sum_pend <= rd_vld && rd_last;
      if (state == IDLE && in_valid)               sum <= in_data;
      else if (state == LOAD && in_valid && !full) sum <= sum + in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (rd_vld) begin
      out_valid <= 1'b1;
      out_data  <= ram_q;
    end else if (sum_pend) begin
      out_valid <= 1'b1;
      out_data  <= sum;
    end else begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= rd_vld;
      out_data  <= rd_vld ? ram_q : '0;
    end
  end
`endif

endmodule

// File: tb/tb_mem_stream_echo.sv
// Self-checking bench for mem_stream_echo: queue-based reference model of burst capture and replay.
import mem_stream_pkg::*;

module tb_mem_stream_echo;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              overflow;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;
  bit model_ovf = 1'b0;

  mem_stream_echo dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mon_en && out_valid !== 1'b1) begin
      n_tests++;
      if (out_data !== '0) begin
        n_fail++;
        $display("[TB] FAIL idle_zero: out_data=%h out_valid=%b, required 0000", out_data, out_valid);
      end
    end
  end

  // Called at a negedge; leaves in_valid low so the next posedge is edge E.
  task automatic drive_burst(input logic [DATA_W-1:0] words[$]);
    foreach (words[i]) begin
      in_valid = 1'b1;
      in_data  = words[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_data  = DATA_W'($urandom);
  endtask

  task automatic check_dump(input string name, input logic [DATA_W-1:0] words[$], input bit noise);
    logic [DATA_W-1:0] exp[$];
    logic [DATA_W-1:0] got[$];
    logic [DATA_W-1:0] sum = '0;
    int first = -1;
    int last = -1;
    int highs = 0;
    int keep;
    keep = (words.size() > DEPTH) ? DEPTH : words.size();
    for (int i = 0; i < keep; i++) begin
      exp.push_back(words[i]);
      sum = sum + words[i];
    end
`ifdef MEM_CHECKSUM_EN
    exp.push_back(sum);
`endif
    if (words.size() > DEPTH) model_ovf = 1'b1;
    for (int cyc = 1; cyc <= exp.size() + 8; cyc++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (first < 0) first = cyc;
        last = cyc;
        highs++;
        got.push_back(out_data);
      end
      in_valid = noise && (cyc <= 3);
      in_data  = DATA_W'($urandom);
    end
    in_valid = 1'b0;
    n_tests++;
    if (first != 3) begin
      n_fail++;
      $display("[TB] FAIL %s_latency: first out_valid at negedge %0d after E, required 3", name, first);
    end
    n_tests++;
    if (highs != exp.size()) begin
      n_fail++;
      $display("[TB] FAIL %s_length: out_valid high %0d cycles, required %0d", name, highs, exp.size());
    end
    n_tests++;
    if (highs > 0 && (last - first + 1) != highs) begin
      n_fail++;
      $display("[TB] FAIL %s_gapless: span %0d cycles for %0d words", name, last - first + 1, highs);
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      n_tests++;
      if (got[i] !== exp[i]) begin
        n_fail++;
        $display("[TB] FAIL %s_data[%0d]: got %h, required %h", name, i, got[i], exp[i]);
      end
    end
    n_tests++;
    if (overflow !== model_ovf) begin
      n_fail++;
      $display("[TB] FAIL %s_overflow: got %b, required %b", name, overflow, model_ovf);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== '0 || overflow !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_state: valid=%b data=%h ovf=%b, required 0 0000 0", out_valid, out_data, overflow);
    end
    rst_n  = 1'b1;
    mon_en = 1'b1;
    model_ovf = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [DATA_W-1:0] q[$];
    q.push_back(16'd1024);
    q.push_back(16'd512);
    drive_burst(q);
    check_dump("basic", q, 1'b0);
  endtask

  task automatic test_single();
    logic [DATA_W-1:0] q[$];
    q.push_back(16'hFFFF);
    drive_burst(q);
    check_dump("single", q, 1'b0);
    q.push_back(16'h0002);
    drive_burst(q);
    check_dump("wrap_pair", q, 1'b0);
  endtask

  task automatic test_random();
    for (int b = 0; b < 4; b++) begin
      logic [DATA_W-1:0] q[$];
      int len = $urandom_range(1, 24);
      for (int i = 0; i < len; i++) q.push_back(DATA_W'($urandom));
      drive_burst(q);
      check_dump("random", q, 1'b0);
    end
  endtask

  task automatic test_dump_noise();
    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] r[$];
    q.push_back(16'd11);
    q.push_back(16'd22);
    drive_burst(q);
    check_dump("noise", q, 1'b1);
    r.push_back(16'd7);
    r.push_back(16'd8);
    drive_burst(r);
    check_dump("after_noise", r, 1'b0);
  endtask

  task automatic test_reset_mid_dump();
    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] r[$];
    bit seen = 1'b0;
    bit stray = 1'b0;
    for (int i = 1; i <= 4; i++) q.push_back(DATA_W'(i * 16'h101));
    drive_burst(q);
    for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("[TB] FAIL middump_start: out_valid never rose within 10 cycles");
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_tests++;
    if (out_valid !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL middump_abort: valid=%b ovf=%b, required 0 0", out_valid, overflow);
    end
    repeat (8) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stray = 1'b1;
    end
    n_tests++;
    if (stray) begin
      n_fail++;
      $display("[TB] FAIL middump_residual: out_valid rose after reset, required 0");
    end
    r.push_back(16'd5);
    r.push_back(16'd6);
    drive_burst(r);
    check_dump("post_reset", r, 1'b0);
  endtask

  task automatic test_full_and_overflow();
    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] r[$];
    logic [DATA_W-1:0] s[$];
    for (int i = 0; i < DEPTH; i++) q.push_back(DATA_W'(i));
    drive_burst(q);
    check_dump("full_ramp", q, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) r.push_back(DATA_W'($urandom));
    drive_burst(r);
    check_dump("overflow", r, 1'b0);
    s.push_back(16'd3);
    drive_burst(s);
    check_dump("ovf_sticky", s, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_ovf = 1'b0;
    n_tests++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL ovf_cleared: got %b, required 0", overflow);
    end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_single();
    test_random();
    test_dump_noise();
    test_reset_mid_dump();
    test_full_and_overflow();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
